seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_div_pkg.sv | 20 ++
 rtl/seq_divider_iter_counter.sv | 33 +++
 rtl/seq_divider.sv | 169 ++++++++++++++++
 tb/tb_seq_divider.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_div_pkg.sv
// -----------------------------------------------------------------------------
// seq_div_pkg
//   Shared definitions for the sequential restoring divider.
//   - state_t   : FSM state encoding (IDLE, OP, DONE)
//   - cnt_width : width of the iteration counter for an N-bit divider
// -----------------------------------------------------------------------------
package seq_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OP   = 2'd1,
        DONE = 2'd2
    } state_t;

    // The counter must hold the value N itself, hence N+1 distinct values.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/seq_divider_iter_counter.sv
// -----------------------------------------------------------------------------
// iter_counter
//   Loadable down-counter used to count the divider iterations.
//   Ports:
//     clk        : rising-edge clock
//     reset      : asynchronous, active-high reset (count -> 0)
//     load       : load load_value (has priority over dec)
//     load_value : value loaded on load
//     dec        : decrement by one; saturates at zero
//     count      : current count
// -----------------------------------------------------------------------------
module iter_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

endmodule

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//   Unsigned N-bit sequential restoring divider, one quotient bit per cycle.
//   A start accepted in IDLE captures the operands; N OP cycles later the
//   FSM enters DONE for one cycle, pulsing done_tick with stable results.
//
//   Optional build macro: SEQ_DIV_ZERO_DETECT_EN
//     defined   : a zero divisor skips the iterations (IDLE->DONE), returns
//                 quotient all ones, remainder = dividend, div_zero = 1.
//     undefined : a zero divisor runs the normal iterations (which naturally
//                 give the same quotient/remainder); div_zero is tied to 0.
//
//   Ports:
//     clk       : rising-edge clock
//     reset     : asynchronous, active-high reset (aborts any operation)
//     start     : begin a division; only sampled while ready is high
//     dividend  : unsigned dividend, captured on the accepted start
//     divisor   : unsigned divisor, captured on the accepted start
//     ready     : high exactly while the FSM is IDLE
//     done_tick : one-cycle pulse in DONE; quotient/remainder valid
//     quotient  : unsigned quotient (held from DONE until the next start)
//     remainder : unsigned remainder (held from DONE until the next start)
//     div_zero  : divisor was zero on the last accepted start
//
//   Handshake: start is a request that is accepted on a rising edge where
//   start && ready; the caller may hold start high, in which case the next
//   request is accepted in the first IDLE cycle after DONE.
// -----------------------------------------------------------------------------
module seq_divider
    import seq_div_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         ready,
    output logic         done_tick,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_zero
);

    localparam int CW = cnt_width(N);

    state_t        state;
    state_t        state_next;
    logic          accept;
    logic          step;
    logic [CW-1:0] count;

    logic [N-1:0]  quo_q;
    logic [N-1:0]  rem_q;
    logic [N-1:0]  div_q;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor if it fits.
    logic [N:0]    t;
    logic          fits;
    logic [N-1:0]  rem_step;

    assign t    = {rem_q, quo_q[N-1]};
    assign fits = (t >= {1'b0, div_q});
    // When t >= divisor the difference is below the divisor, so it fits in
    // N bits and the low-order subtraction is exact.
    assign rem_step = fits ? (t[N-1:0] - div_q) : t[N-1:0];

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
`ifdef SEQ_DIV_ZERO_DETECT_EN
                    state_next = (divisor == '0) ? DONE : OP;
`else
                    state_next = OP;
`endif
                end
            end
            // The counter is decremented on this same edge; the step that
            // takes it from 1 to 0 is the last one.
            OP:      if (count <= CW'(1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        ready     = (state == IDLE);
        done_tick = (state == DONE);
        step      = (state == OP);
        accept    = (state == IDLE) && start;
    end

    iter_counter #(
        .W (CW)
    ) u_iter_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (accept),
        .load_value (CW'(N)),
        .dec        (step),
        .count      (count)
    );

    // ---------------- Datapath ----------------
`ifdef SEQ_DIV_ZERO_DETECT_EN
    logic dz_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            quo_q <= '0;
            rem_q <= '0;
            div_q <= '0;
            dz_q  <= 1'b0;
        end else if (accept) begin
            div_q <= divisor;
            if (divisor == '0) begin
                quo_q <= '1;
                rem_q <= dividend;
                dz_q  <= 1'b1;
            end else begin
                quo_q <= dividend;
                rem_q <= '0;
                dz_q  <= 1'b0;
            end
        end else if (step) begin
            quo_q <= {quo_q[N-2:0], fits};
            rem_q <= rem_step;
        end
    end

    assign div_zero = dz_q;
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            quo_q <= '0;
            rem_q <= '0;
            div_q <= '0;
        end else if (accept) begin
            quo_q <= dividend;
            rem_q <= '0;
            div_q <= divisor;
        end else if (step) begin
            quo_q <= {quo_q[N-2:0], fits};
            rem_q <= rem_step;
        end
    end

    assign div_zero = 1'b0;
`endif

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
//   Directed self-checking bench for seq_divider (N = 8). Each scenario task
//   drives its own stimulus and compares against hand-computed values.
//   Latency is counted in falling edges after the accepting rising edge:
//   the first cycle after acceptance is cycle 1.
// -----------------------------------------------------------------------------
module tb_seq_divider;

    localparam int N = 8;

    logic         clk;
    logic         reset;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         ready;
    logic         done_tick;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_zero;

    int tests_run    = 0;
    int tests_failed = 0;

    seq_divider #(.N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .ready     (ready),
        .done_tick (done_tick),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    // Present a request at a falling edge, let the next rising edge accept
    // it, then withdraw start.
    task automatic do_start(input logic [N-1:0] a, input logic [N-1:0] b);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Wait for done_tick; lat = cycle it appeared (or -1 on timeout),
    // low = cycles seen with ready low up to and including that cycle.
    task automatic wait_done(output int lat, output int low);
        lat = -1;
        low = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (!ready) low++;
            if (done_tick) begin
                lat = c;
                break;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        dividend = '0;
        divisor  = '0;
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if ({ready, done_tick, quotient, remainder, div_zero} !== {1'b1, 1'b0, 8'd0, 8'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_during: rdy=%b done=%b q=%0d r=%0d dz=%b, need 1 0 0 0 0",
                     ready, done_tick, quotient, remainder, div_zero);
        end
        reset = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({ready, done_tick} !== 2'b10) begin
            tests_failed++;
            $display("FAIL reset_after: rdy=%b done=%b, need 1 0", ready, done_tick);
        end
    endtask

    // One complete division with result, latency and div_zero checks.
    task automatic run_check(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                             input logic [N-1:0] exp_q, input logic [N-1:0] exp_r,
                             input logic exp_dz, input int exp_lat);
        int lat, low;
        do_start(a, b);
        wait_done(lat, low);
        tests_run++;
        if (lat !== exp_lat) begin
            tests_failed++;
            $display("FAIL %s_latency: got %0d, need %0d", name, lat, exp_lat);
        end
        tests_run++;
        if ({quotient, remainder, div_zero} !== {exp_q, exp_r, exp_dz}) begin
            tests_failed++;
            $display("FAIL %s_result: q=%0d r=%0d dz=%b, need q=%0d r=%0d dz=%b",
                     name, quotient, remainder, div_zero, exp_q, exp_r, exp_dz);
        end
    endtask

    task automatic test_basic();
        int lat, low;
        do_start(8'd100, 8'd7);
        wait_done(lat, low);
        tests_run++;
        if (lat !== 9) begin
            tests_failed++;
            $display("FAIL basic_latency: got %0d, need 9", lat);
        end
        tests_run++;
        if ({quotient, remainder, div_zero} !== {8'd14, 8'd2, 1'b0}) begin
            tests_failed++;
            $display("FAIL basic_result: q=%0d r=%0d dz=%b, need 14 2 0", quotient, remainder, div_zero);
        end
        tests_run++;
        if (low !== 9) begin
            tests_failed++;
            $display("FAIL basic_ready_low: got %0d cycles, need 9", low);
        end
        // Results must hold after DONE while idle.
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if ({ready, done_tick, quotient, remainder} !== {1'b1, 1'b0, 8'd14, 8'd2}) begin
            tests_failed++;
            $display("FAIL basic_hold: rdy=%b done=%b q=%0d r=%0d, need 1 0 14 2",
                     ready, done_tick, quotient, remainder);
        end
    endtask

    task automatic test_boundaries();
        run_check("max_by_one", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 9);
        run_check("small_by_big", 8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 9);
`ifdef SEQ_DIV_ZERO_DETECT_EN
        run_check("div_by_zero", 8'd200, 8'd0, 8'd255, 8'd200, 1'b1, 1);
`else
        run_check("div_by_zero", 8'd200, 8'd0, 8'd255, 8'd200, 1'b0, 9);
`endif
    endtask

    task automatic test_ignore_start();
        int lat = -1;
        int low = 0;
        do_start(8'd100, 8'd7);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (!ready) low++;
            if (done_tick) begin
                lat = c;
                break;
            end
            if (c == 3) begin
                start    = 1'b1;
                dividend = 8'd50;
                divisor  = 8'd5;
            end
            if (c == 4) start = 1'b0;
        end
        tests_run++;
        if (lat !== 9 || low !== 9) begin
            tests_failed++;
            $display("FAIL ignore_timing: lat=%0d ready_low=%0d, need 9 9", lat, low);
        end
        tests_run++;
        if ({quotient, remainder} !== {8'd14, 8'd2}) begin
            tests_failed++;
            $display("FAIL ignore_result: q=%0d r=%0d, need 14 2", quotient, remainder);
        end
    endtask

    task automatic test_reset_abort();
        int pulses = 0;
        do_start(8'd100, 8'd7);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        tests_run++;
        if ({ready, done_tick, quotient, remainder, div_zero} !== {1'b1, 1'b0, 8'd0, 8'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL abort_outputs: rdy=%b done=%b q=%0d r=%0d dz=%b, need 1 0 0 0 0",
                     ready, done_tick, quotient, remainder, div_zero);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (done_tick || !ready) pulses++;
        end
        tests_run++;
        if (pulses !== 0) begin
            tests_failed++;
            $display("FAIL abort_no_done: got %0d busy/done cycles, need 0", pulses);
        end
        run_check("after_abort", 8'd9, 8'd4, 8'd2, 8'd1, 1'b0, 9);
    endtask

    task automatic test_back_to_back();
        int lat1, lat2, low;
        logic rdy_gap;
        @(negedge clk);
        start    = 1'b1;
        dividend = 8'd9;
        divisor  = 8'd4;
        @(posedge clk);
        wait_done(lat1, low);
        tests_run++;
        if (lat1 !== 9 || {quotient, remainder} !== {8'd2, 8'd1}) begin
            tests_failed++;
            $display("FAIL b2b_first: lat=%0d q=%0d r=%0d, need 9 2 1", lat1, quotient, remainder);
        end
        // start still high: first IDLE cycle must be the accepting one.
        @(negedge clk);
        rdy_gap = ready;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat2, low);
        tests_run++;
        if (rdy_gap !== 1'b1 || lat2 !== 9) begin
            tests_failed++;
            $display("FAIL b2b_second_timing: idle_ready=%b lat=%0d, need 1 9", rdy_gap, lat2);
        end
        tests_run++;
        if ({quotient, remainder} !== {8'd2, 8'd1}) begin
            tests_failed++;
            $display("FAIL b2b_second_result: q=%0d r=%0d, need 2 1", quotient, remainder);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
